// File: rtl/fb_mem_arbiter.sv
// fb_mem_arbiter: round-robin single-port frame buffer arbiter (scanout read vs pixel write)
module fb_mem_arbiter #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 24,
  parameter int QUANTUM = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_urgent,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              busy,
  output logic              rd_err
);
  localparam logic [1:0] IDLE = 2'd0, GRANT_RD = 2'd1, GRANT_WR = 2'd2;
  localparam int QW = $clog2(QUANTUM + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  logic [1:0] st, arb, nxt;
  logic lg_wr;
  logic [QW-1:0] qcnt;
  logic [OW-1:0] outstanding;
  logic g_rd, g_wr, can_issue, accept, x_req, other_req, q_end, leave;
  assign g_rd = st == GRANT_RD;
  assign g_wr = st == GRANT_WR;
  assign can_issue = int'(outstanding) < MAX_OUTSTANDING;
  assign mem_req = g_rd ? rd_req && can_issue : g_wr && wr_req;
  assign mem_we = g_wr;
  assign mem_addr = g_rd ? rd_addr : g_wr ? wr_addr : '0;
  assign mem_wdata = g_wr ? wr_data : '0;
  assign accept = mem_req && mem_ack;
  assign rd_ack = g_rd && accept;
  assign wr_ack = g_wr && accept;
  assign busy = st != IDLE || outstanding != '0;
  assign arb = rd_req && (rd_urgent || !wr_req || lg_wr) ? GRANT_RD : wr_req ? GRANT_WR : IDLE;
  assign x_req = g_rd ? rd_req : wr_req;
  assign other_req = g_rd ? wr_req : rd_req;
  // >= rather than == so a saturated lone-requester quantum still yields once the other side asks
  assign q_end = int'(qcnt) + 1 >= QUANTUM;
  assign leave = st == IDLE || !x_req
              || (q_end && other_req && (accept || (g_rd && !can_issue)))
              || (g_wr && accept && rd_req && rd_urgent);
  assign nxt = leave ? arb : st;
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      lg_wr <= 1'b1;
      qcnt <= '0;
      outstanding <= '0;
      rd_err <= 1'b0;
      rd_valid <= 1'b0;
      rd_data <= '0;
    end else begin
      st <= nxt;
      if (leave && arb != IDLE) begin
        lg_wr <= arb == GRANT_WR;
        qcnt <= '0;
      end else if (accept && int'(qcnt) < QUANTUM) qcnt <= qcnt + 1'b1;
      outstanding <= outstanding + OW'(rd_ack) - OW'(mem_rvalid && outstanding != '0);
      rd_err <= rd_err | (mem_rvalid && outstanding == '0);
      rd_valid <= mem_rvalid;
      if (mem_rvalid) rd_data <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_fb_mem_arbiter.sv
// tb_fb_mem_arbiter: directed scoreboard bench for fb_mem_arbiter
module tb_fb_mem_arbiter;
  localparam int AW = 19, DW = 24;
  logic clk = 0, rst = 1;
  logic rd_req = 0, rd_urgent = 0, wr_req = 0, mem_ack = 0, mem_rvalid = 0;
  logic [AW-1:0] rd_addr = '0, wr_addr = '0;
  logic [DW-1:0] wr_data = '0, mem_rdata = '0;
  logic rd_ack, rd_valid, wr_ack, mem_req, mem_we, busy, rd_err;
  logic [DW-1:0] rd_data, mem_wdata;
  logic [AW-1:0] mem_addr;
  always #5 clk = ~clk;
  fb_mem_arbiter dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr), .rd_urgent(rd_urgent),
    .rd_ack(rd_ack), .rd_data(rd_data), .rd_valid(rd_valid), .wr_req(wr_req),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .busy(busy), .rd_err(rd_err)
  );
  int npass = 0, nfail = 0, ntot = 0, rd_left = 0, wr_left = 0, n = 0;
  logic [AW-1:0] exp_rd[$], exp_wr[$];
  logic [DW-1:0] pend[$], rq[$];
  logic grants[$];
  logic ack_en = 0, ret_en = 0, inj = 0, exp_rv = 0;
  logic [DW-1:0] inj_data = '0;
  function automatic logic [DW-1:0] rdfn(input logic [AW-1:0] a);
    return {5'h15, a};
  endfunction
  function automatic logic [DW-1:0] pix(input logic [AW-1:0] a);
    return {a[11:0], ~a[11:0]};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    ntot++;
    assert (got === want) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask
  task automatic start_rd(input int cnt, input logic [AW-1:0] a);
    for (int i = 0; i < cnt; i++) exp_rd.push_back(a + AW'(i));
    rd_left = cnt;
    rd_addr = a;
    rd_req = 1;
  endtask
  task automatic start_wr(input int cnt, input logic [AW-1:0] a);
    for (int i = 0; i < cnt; i++) exp_wr.push_back(a + AW'(i));
    wr_left = cnt;
    wr_addr = a;
    wr_data = pix(a);
    wr_req = 1;
  endtask
  // one cycle: drive memory side at negedge, sample before posedge, advance clients after it
  task automatic tick();
    logic acc, racc, wacc;
    logic [AW-1:0] a;
    mem_ack = ack_en;
    mem_rvalid = 0;
    exp_rv = 0;
    if (inj) begin
      mem_rvalid = 1;
      mem_rdata = inj_data;
      inj = 0;
    end else if (ret_en && pend.size() > 0) begin
      mem_rvalid = 1;
      mem_rdata = pend.pop_front();
    end
    if (mem_rvalid) begin
      rq.push_back(mem_rdata);
      exp_rv = 1;
    end
    #2;
    acc = mem_req && mem_ack;
    racc = acc && !mem_we;
    wacc = acc && mem_we;
    chk("rd_ack", rd_ack, racc);
    chk("wr_ack", wr_ack, wacc);
    if (wacc) begin
      grants.push_back(1'b1);
      chk("wr_pending", 32'(exp_wr.size() > 0), 1);
      if (exp_wr.size() > 0) begin
        a = exp_wr.pop_front();
        chk("wr_addr", mem_addr, a);
        chk("wr_data", mem_wdata, pix(a));
      end
    end
    if (racc) begin
      grants.push_back(1'b0);
      chk("rd_pending", 32'(exp_rd.size() > 0), 1);
      if (exp_rd.size() > 0) chk("rd_addr", mem_addr, exp_rd.pop_front());
      pend.push_back(rdfn(mem_addr));
    end
    @(negedge clk);
    chk("rd_valid", rd_valid, exp_rv);
    if (exp_rv && rq.size() > 0) chk("rd_data", rd_data, rq.pop_front());
    if (wacc) begin
      wr_left--;
      wr_addr = wr_addr + 1'b1;
      wr_data = pix(wr_addr);
      wr_req = wr_left > 0;
    end
    if (racc) begin
      rd_left--;
      rd_addr = rd_addr + 1'b1;
      rd_req = rd_left > 0;
    end
  endtask
  task automatic clear_tb();
    rd_req = 0; wr_req = 0; rd_urgent = 0; rd_left = 0; wr_left = 0;
    ret_en = 0; ack_en = 0; inj = 0;
    pend.delete(); exp_rd.delete(); exp_wr.delete(); rq.delete(); grants.delete();
  endtask
  task automatic reset_dut();
    clear_tb();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
  initial begin
    @(negedge clk);
    reset_dut();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_err", rd_err, 0);
    ack_en = 1;
    for (int i = 0; i < 3; i++) tick();
    chk("idle_busy", busy, 0);
    // lone write burst
    start_wr(20, 19'd0);
    n = 0;
    while (wr_left > 0 && n < 100) begin tick(); n++; end
    chk("t2_cycles", n, 21);
    chk("t2_count", 32'(grants.size()), 20);
    tick(); tick();
    chk("t2_idle_busy", busy, 0);
    // contention round robin
    reset_dut();
    ack_en = 1; ret_en = 1;
    start_rd(16, 19'h100);
    start_wr(16, 19'h200);
    n = 0;
    while ((rd_left > 0 || wr_left > 0) && n < 100) begin tick(); n++; end
    chk("t3_cycles", n, 33);
    chk("t3_count", 32'(grants.size()), 32);
    if (grants.size() >= 24)
      for (int i = 0; i < 24; i++) chk("t3_order", grants[i], i >= 8 && i < 16);
    tick(); tick();
    grants.delete();
    // urgent preemption
    start_wr(10, 19'h300);
    n = 0;
    while (wr_left > 8 && n < 20) begin tick(); n++; end
    chk("t4_pre_cycles", n, 3);
    start_rd(2, 19'h400);
    rd_urgent = 1;
    tick();
    tick();
    rd_urgent = 0;
    chk("t4_after_3rd", 32'(grants.size()), 4);
    if (grants.size() >= 4) chk("t4_is_read", grants[3], 0);
    n = 0;
    while ((rd_left > 0 || wr_left > 0) && n < 50) begin tick(); n++; end
    chk("t4_total", 32'(grants.size()), 12);
    tick(); tick();
    // outstanding limit
    ret_en = 0;
    start_rd(6, 19'h500);
    for (int i = 0; i < 8; i++) tick();
    chk("t5_accepted", rd_left, 2);
    chk("t5_blocked_req", mem_req, 0);
    chk("t5_busy", busy, 1);
    if (pend.size() > 0) pend[0] = 24'hABCDEF;
    ret_en = 1;
    tick();
    ret_en = 0;
    chk("t5_rd_valid", rd_valid, 1);
    chk("t5_rd_data", rd_data, 24'hABCDEF);
    for (int i = 0; i < 3; i++) tick();
    chk("t5_one_more", rd_left, 1);
    chk("t5_valid_low", rd_valid, 0);
    ret_en = 1;
    n = 0;
    while ((rd_left > 0 || pend.size() > 0) && n < 50) begin tick(); n++; end
    tick(); tick();
    chk("t5_drained", busy, 0);
    // error and reset mid-op
    inj = 1;
    inj_data = 24'h123456;
    tick();
    chk("t6_err", rd_err, 1);
    tick();
    chk("t6_err_sticky", rd_err, 1);
    chk("t6_busy", busy, 0);
    ret_en = 0;
    start_rd(1, 19'h700);
    tick(); tick();
    start_wr(5, 19'h600);
    ack_en = 0;
    tick(); tick();
    chk("t6_wr_req_held", mem_req, 1);
    chk("t6_we", mem_we, 1);
    chk("t6_busy_pre", busy, 1);
    rst = 1;
    tick();
    chk("t6_rst_mem_req", mem_req, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_err", rd_err, 0);
    clear_tb();
    rst = 0;
    tick();
    chk("t6_post_busy", busy, 0);
    chk("t6_post_req", mem_req, 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/fb_mem_arbiter.md
Name: fb_mem_arbiter

Overview:
Single-port arbiter sharing the frame buffer memory between the scanout reader (display refresh) and the pixel writer (ray tracer output). It sits between FrameBufferController's read/write clients and the memory interface. It uses round-robin with a per-grant burst quantum and a read-urgency override, so scanout never underruns and writes never starve. It also tracks in-flight reads and forwards returned read data.

Parameters:
ADDR_W, 19, frame buffer word address width
DATA_W, 24, pixel word width (RGB8 packed R[23:16] G[15:8] B[7:0])
QUANTUM, 8, max accepted transfers per grant while the other requester waits
MAX_OUTSTANDING, 4, max reads issued but not yet returned (power of 2 not required, >=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rd_req  in  1  scanout read request; held with rd_addr stable until rd_ack
rd_addr  in  ADDR_W  read address
rd_urgent  in  1  scanout FIFO below low watermark
rd_ack  out  1  one-cycle pulse: read accepted by memory
rd_data  out  DATA_W  returned read data, registered
rd_valid  out  1  one-cycle pulse qualifying rd_data
wr_req  in  1  pixel write request; held with wr_addr/wr_data stable until wr_ack
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
wr_ack  out  1  one-cycle pulse: write accepted by memory
mem_req  out  1  memory request; fields stable until mem_ack
mem_we  out  1  1=write, 0=read
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_ack  in  1  memory accepts the current request (single-cycle pulse)
mem_rdata  in  DATA_W  read return data
mem_rvalid  in  1  read return strobe; returns are in issue order
busy  out  1  state != IDLE or outstanding != 0
rd_err  out  1  sticky: mem_rvalid received with outstanding == 0

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, last_grant=WR (so the first contested grant goes to RD), qcnt=0, outstanding=0. All outputs 0; rd_data=0.
- Reset mid-operation aborts any pending request immediately. The memory side shares rst.
- States: IDLE, GRANT_RD, GRANT_WR (registered). The grant applies the cycle after the decision, giving 1-cycle arbitration latency from IDLE.
- Arbitration function ARB:
  - RD if rd_req && (rd_urgent || !wr_req || last_grant==WR);
  - else WR if wr_req;
  - else IDLE.
- IDLE: next = ARB. Entering GRANT_X sets last_grant=X and qcnt=0.
- GRANT_RD:
  - mem_req = rd_req && rd_can_issue, where rd_can_issue = outstanding<MAX_OUTSTANDING.
  - mem_we=0, mem_addr=rd_addr.
  - rd_ack = mem_ack.
- GRANT_WR:
  - mem_req = wr_req, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data.
  - wr_ack = mem_ack.
- mem_* fields are combinational from the granted client. In IDLE mem_req=0 and fields are 0.
- On accept (mem_ack): qcnt+=1.
- Leave GRANT_X (next = ARB, no idle bubble) when any of:
  - (a) x_req==0;
  - (b) accept && qcnt+1==QUANTUM && other_req;
  - (c) X==WR && accept && rd_req && rd_urgent.
- Otherwise stay in GRANT_X.
- (c) preempts a write burst only at a transfer boundary. A request is never withdrawn between mem_req and mem_ack.
- A lone requester keeps its grant indefinitely; qcnt saturates at QUANTUM.
- Outstanding counter:
  - +1 on read accept, -1 on mem_rvalid; simultaneous events leave it unchanged.
  - At MAX_OUTSTANDING the read mem_req is held low. The arbiter keeps GRANT_RD unless rule (b) or (c) applies; rule (b) is evaluated using wr_req as other_req even without an accept.
- Read return: rd_data<=mem_rdata and rd_valid<=1 on mem_rvalid (1-cycle latency); otherwise rd_valid<=0.
- rvalid with outstanding==0 sets rd_err and leaves the counter at 0.
- mem_ack while mem_req==0 is ignored: no ack pulses, no counter change.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles, no requests -> all outputs 0, busy=0; mem_ack=1 strobes cause no rd_ack/wr_ack.
2. Lone write burst: wr_req held 20 transfers, addr 0..19, mem_ack every cycle -> GRANT_WR one cycle after wr_req; 20 wr_ack pulses, no gaps, mem_we=1, mem_wdata matches each address.
3. Contention round-robin, QUANTUM=8: rd_req and wr_req both held from reset, mem_ack every cycle -> grant order RD x8, WR x8, RD x8; switches with no idle cycle.
4. Urgent preemption: write burst in progress at transfer 3; assert rd_urgent with rd_req -> grant moves to RD on the cycle after the 3rd wr_ack; the next mem_req is a read.
5. Outstanding limit: mem_rvalid withheld, 6 reads requested -> 4 rd_ack then mem_req=0. One mem_rvalid with data 0xABCDEF -> rd_valid/rd_data=0xABCDEF next cycle; exactly one more read issues.
6. Error and reset mid-op: mem_rvalid with 0 outstanding -> rd_err=1 sticky. rst pulsed during GRANT_WR with mem_req high -> next cycle state IDLE, mem_req=0, rd_err=0, outstanding=0.
